// File: rtl/mini_mips_pkg.sv
// Shared constants for the mini_mips core: instruction field positions,
// opcodes, R-type function codes and the immediate sign-extension helper.
package mini_mips_pkg;

    localparam int OP_HI    = 15;
    localparam int OP_LO    = 12;
    localparam int RS_HI    = 11;
    localparam int RS_LO    = 9;
    localparam int RT_HI    = 8;
    localparam int RT_LO    = 6;
    localparam int RD_HI    = 5;
    localparam int RD_LO    = 3;
    localparam int FUNCT_HI = 2;
    localparam int FUNCT_LO = 0;
    localparam int IMM_HI   = 5;
    localparam int IMM_LO   = 0;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_ANDI  = 4'h2;
    localparam logic [3:0] OP_ORI   = 4'h3;
    localparam logic [3:0] OP_SLTI  = 4'h4;
    localparam logic [3:0] OP_LW    = 4'h5;
    localparam logic [3:0] OP_SW    = 4'h6;
    localparam logic [3:0] OP_BEQ   = 4'h7;
    localparam logic [3:0] OP_BNE   = 4'h8;

    localparam logic [2:0] F_ADD  = 3'd0;
    localparam logic [2:0] F_SUB  = 3'd1;
    localparam logic [2:0] F_AND  = 3'd2;
    localparam logic [2:0] F_OR   = 3'd3;
    localparam logic [2:0] F_XOR  = 3'd4;
    localparam logic [2:0] F_NOR  = 3'd5;
    localparam logic [2:0] F_SLT  = 3'd6;
    localparam logic [2:0] F_SLLV = 3'd7;

    function automatic logic [31:0] sext6(input logic [5:0] v);
        return {{26{v[5]}}, v};
    endfunction

endpackage

// File: rtl/mini_mips_alu.sv
// Combinational ALU: selects the operation from opcode (and funct for R-type).
// Opcodes 1001-1111 produce zero.
module mini_mips_alu
    import mini_mips_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [2:0]  funct,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_ADD:   result = a + b;
                    F_SUB:   result = a - b;
                    F_AND:   result = a & b;
                    F_OR:    result = a | b;
                    F_XOR:   result = a ^ b;
                    F_NOR:   result = ~(a | b);
                    F_SLT:   result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: result = a << b[4:0];
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: result = a + b;
            OP_ANDI:               result = a & b;
            OP_ORI:                result = a | b;
            OP_SLTI:               result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_BEQ, OP_BNE:        result = a - b;
            default:               result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/mini_mips_dmem.sv
// 256x32 data memory: combinational read, write on the rising edge.
module mini_mips_dmem (
    input  logic        clk,
    input  logic        we,
    input  logic [7:0]  addr,
    input  logic [31:0] wd,
    output logic [31:0] rd
);

    logic [31:0] data_memory [0:255];

    always_ff @(posedge clk) begin
        if (we) begin
            data_memory[addr] <= wd;
        end
    end

    assign rd = data_memory[addr];

endmodule

// File: rtl/mini_mips_imem.sv
// 256x16 instruction memory with combinational fetch. The load port allows
// in-system programming; the core ties it off and relies on preload.
module mini_mips_imem (
    input  logic        clk,
    input  logic        load_en,
    input  logic [7:0]  load_addr,
    input  logic [15:0] load_data,
    input  logic [7:0]  addr,
    output logic [15:0] data
);

    logic [15:0] instruction_memory [0:255];

    always_ff @(posedge clk) begin
        if (load_en) begin
            instruction_memory[load_addr] <= load_data;
        end
    end

    assign data = instruction_memory[addr];

endmodule

// File: rtl/mini_mips_regfile.sv
// 8x32 register file, two combinational read ports, one write port.
// Register 0 reads as zero and ignores writes; contents are not reset.
module mini_mips_regfile (
    input  logic        clk,
    input  logic        we,
    input  logic [2:0]  ra1,
    input  logic [2:0]  ra2,
    input  logic [2:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] registers [0:7];

    always_ff @(posedge clk) begin
        if (we && (wa != 3'd0)) begin
            registers[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 3'd0) ? 32'd0 : registers[ra1];
    assign rd2 = (ra2 == 3'd0) ? 32'd0 : registers[ra2];

endmodule

// File: rtl/mini_mips.sv
// Single-cycle MIPS-style core: 16-bit instructions, 32-bit datapath,
// one instruction committed per rising edge.
module mini_mips
    import mini_mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] instruction,
    output logic [31:0] result
);

    logic [7:0]  pc_reg;
    logic [7:0]  pc_next;
    logic [3:0]  op;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic [2:0]  funct;
    logic [5:0]  imm6;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm_ext;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic [31:0] dmem_rd;
    logic        writes_reg;
    logic        reg_we;
    logic [2:0]  reg_wa;
    logic [31:0] reg_wd;
    logic        dmem_we;
    logic        branch_taken;
    logic [7:0]  branch_off;

    assign op    = instruction[OP_HI:OP_LO];
    assign rs    = instruction[RS_HI:RS_LO];
    assign rt    = instruction[RT_HI:RT_LO];
    assign rd    = instruction[RD_HI:RD_LO];
    assign funct = instruction[FUNCT_HI:FUNCT_LO];
    assign imm6  = instruction[IMM_HI:IMM_LO];

    mini_mips_imem miInst (
        .clk       (clk),
        .load_en   (1'b0),
        .load_addr (8'd0),
        .load_data (16'd0),
        .addr      (pc_reg),
        .data      (instruction)
    );

    mini_mips_regfile mrInst (
        .clk (clk),
        .we  (reg_we),
        .ra1 (rs),
        .ra2 (rt),
        .wa  (reg_wa),
        .wd  (reg_wd),
        .rd1 (rs_val),
        .rd2 (rt_val)
    );

    // andi/ori take a zero-extended immediate; everything else sign-extends
    assign imm_ext = (op == OP_ANDI || op == OP_ORI) ? {26'd0, imm6} : sext6(imm6);
    assign alu_b   = (op == OP_RTYPE || op == OP_BEQ || op == OP_BNE) ? rt_val : imm_ext;

    mini_mips_alu u_alu (
        .op     (op),
        .funct  (funct),
        .a      (rs_val),
        .b      (alu_b),
        .result (alu_result),
        .zero   (alu_zero)
    );

    assign result = alu_result;

    mini_mips_dmem mdInst (
        .clk  (clk),
        .we   (dmem_we),
        .addr (alu_result[7:0]),
        .wd   (rt_val),
        .rd   (dmem_rd)
    );

    always_comb begin
        writes_reg = 1'b0;
        case (op)
            OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LW: writes_reg = 1'b1;
            default: writes_reg = 1'b0;
        endcase
    end

    // Reset level masks both write enables so an edge during reset commits nothing
    assign reg_we  = writes_reg && !reset;
    assign reg_wa  = (op == OP_RTYPE) ? rd : rt;
    assign reg_wd  = (op == OP_LW) ? dmem_rd : alu_result;
    assign dmem_we = (op == OP_SW) && !reset;

    assign branch_taken = ((op == OP_BEQ) && alu_zero) || ((op == OP_BNE) && !alu_zero);
    assign branch_off   = branch_taken ? {imm6[5], imm6[5], imm6} : 8'd0;
    assign pc_next      = pc_reg + 8'd1 + branch_off;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg <= 8'd0;
        end else begin
            pc_reg <= pc_next;
        end
    end

endmodule

// File: tb/tb_mini_mips.sv
// Directed bench for mini_mips: per-instruction checks, asynchronous reset
// abort, and a 36-cycle program with PC wrap followed by a state dump.
module tb_mini_mips;
    import mini_mips_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] instruction;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_regs [0:7];

    mini_mips dut (
        .clk         (clk),
        .reset       (rst),
        .instruction (instruction),
        .result      (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    function automatic logic [15:0] enc_r(input logic [2:0] f, input int rs, input int rt, input int rd);
        logic [2:0] s, t, d;
        s = rs[2:0]; t = rt[2:0]; d = rd[2:0];
        return {OP_RTYPE, s, t, d, f};
    endfunction

    function automatic logic [15:0] enc_i(input logic [3:0] op, input int rs, input int rt, input int imm);
        logic [2:0] s, t;
        logic [5:0] m;
        s = rs[2:0]; t = rt[2:0]; m = imm[5:0];
        return {op, s, t, m};
    endfunction

    task automatic clear_all();
        for (int i = 0; i < 256; i++) begin
            dut.miInst.instruction_memory[i] <= 16'hF000;
            dut.mdInst.data_memory[i]        <= 32'd0;
        end
        for (int r = 0; r < 8; r++) dut.mrInst.registers[r] <= 32'd0;
    endtask

    // check the combinational result, then let one edge commit
    task automatic step(input string tag, input logic [31:0] exp_result);
        chk(tag, result, exp_result);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        clear_all();
        #1;
        dut.miInst.instruction_memory[0]  <= enc_i(OP_ADDI, 0, 1, 5);
        dut.miInst.instruction_memory[1]  <= enc_r(F_ADD, 1, 1, 2);
        dut.miInst.instruction_memory[2]  <= enc_r(F_SUB, 0, 1, 3);
        dut.miInst.instruction_memory[3]  <= enc_r(F_SLT, 3, 1, 4);
        dut.miInst.instruction_memory[4]  <= enc_r(F_SLLV, 1, 1, 5);
        dut.miInst.instruction_memory[5]  <= enc_i(OP_SW, 0, 1, 3);
        dut.miInst.instruction_memory[6]  <= enc_i(OP_LW, 0, 6, 3);
        dut.miInst.instruction_memory[7]  <= enc_i(OP_ADDI, 0, 0, 7);
        dut.miInst.instruction_memory[8]  <= enc_i(OP_ANDI, 3, 7, 6'h3F);
        dut.miInst.instruction_memory[9]  <= enc_i(OP_BNE, 1, 1, 4);
        dut.miInst.instruction_memory[10] <= enc_i(OP_BEQ, 1, 1, -2);

        @(negedge clk);
        chk("reset_pc", {24'd0, dut.pc_reg}, 32'd0);
        chk("reset_instr", {16'd0, instruction}, {16'd0, 16'h1045});
        chk("reset_result", result, 32'd5);
        rst = 1'b0;

        step("addi_result", 32'd5);
        chk("addi_r1", dut.mrInst.registers[1], 32'd5);
        step("add_result", 32'd10);
        chk("add_r2", dut.mrInst.registers[2], 32'd10);
        step("sub_result", 32'hFFFF_FFFB);
        chk("sub_r3", dut.mrInst.registers[3], 32'hFFFF_FFFB);
        step("slt_result", 32'd1);
        chk("slt_r4", dut.mrInst.registers[4], 32'd1);
        step("sllv_result", 32'd160);
        chk("sllv_r5", dut.mrInst.registers[5], 32'd160);
        step("sw_addr", 32'd3);
        chk("sw_dmem3", dut.mdInst.data_memory[3], 32'd5);
        step("lw_addr", 32'd3);
        chk("lw_r6", dut.mrInst.registers[6], 32'd5);
        step("addi_r0_result", 32'd7);
        chk("r0_stays_zero", dut.mrInst.registers[0], 32'd0);
        step("andi_result", 32'h3B);
        chk("andi_r7", dut.mrInst.registers[7], 32'h3B);
        step("bne_result", 32'd0);
        chk("bne_not_taken_pc", {24'd0, dut.pc_reg}, 32'd10);
        step("beq_result", 32'd0);
        chk("beq_taken_pc", {24'd0, dut.pc_reg}, 32'd9);

        // restart, run to PC 6, then assert reset between edges
        rst = 1'b1;
        #1;
        chk("async_reset_pc", {24'd0, dut.pc_reg}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) @(negedge clk);
        chk("run_to_pc6", {24'd0, dut.pc_reg}, 32'd6);
        #2;
        dut.mrInst.registers[1] <= 32'd99;
        #1;
        rst = 1'b1;
        #1;
        chk("midcycle_reset_pc", {24'd0, dut.pc_reg}, 32'd0);
        chk("midcycle_reset_instr", {16'd0, instruction}, {16'd0, 16'h1045});
        chk("midcycle_reset_result", result, 32'd5);
        @(negedge clk);
        chk("reset_edge_no_write", dut.mrInst.registers[1], 32'd99);
        chk("reset_edge_pc", {24'd0, dut.pc_reg}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("release_r1", dut.mrInst.registers[1], 32'd5);
        chk("release_pc", {24'd0, dut.pc_reg}, 32'd1);

        // 36-cycle program that jumps back across the wrap and returns through 255->0
        rst = 1'b1;
        clear_all();
        #1;
        dut.miInst.instruction_memory[0]   <= enc_i(OP_BEQ, 7, 0, -8);
        dut.miInst.instruction_memory[249] <= enc_i(OP_ADDI, 0, 1, 3);
        dut.miInst.instruction_memory[250] <= enc_i(OP_ADDI, 1, 2, -1);
        dut.miInst.instruction_memory[251] <= enc_r(F_SLLV, 1, 2, 3);
        dut.miInst.instruction_memory[252] <= enc_i(OP_SW, 1, 3, 10);
        dut.miInst.instruction_memory[253] <= enc_i(OP_LW, 0, 4, 13);
        dut.miInst.instruction_memory[254] <= enc_r(F_SUB, 2, 4, 5);
        dut.miInst.instruction_memory[255] <= enc_i(OP_ADDI, 0, 7, 1);
        dut.miInst.instruction_memory[1]   <= enc_r(F_XOR, 5, 1, 6);
        dut.miInst.instruction_memory[2]   <= enc_r(F_NOR, 6, 0, 6);
        dut.miInst.instruction_memory[3]   <= enc_i(OP_SLTI, 5, 2, -9);
        dut.miInst.instruction_memory[4]   <= enc_i(OP_SW, 1, 6, -1);
        dut.miInst.instruction_memory[5]   <= enc_r(F_OR, 6, 3, 5);
        dut.miInst.instruction_memory[6]   <= enc_r(F_AND, 4, 5, 4);
        dut.miInst.instruction_memory[7]   <= enc_i(OP_ORI, 1, 1, 6'h30);
        dut.miInst.instruction_memory[8]   <= enc_i(OP_SW, 1, 1, 31);
        dut.miInst.instruction_memory[9]   <= enc_i(OP_ADDI, 0, 0, 5);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            if (c == 1) chk("prog_jump_pc", {24'd0, dut.pc_reg}, 32'd249);
            if (c == 8) chk("prog_wrap_pc", {24'd0, dut.pc_reg}, 32'd0);
            if (c == 9) chk("prog_fallthru_pc", {24'd0, dut.pc_reg}, 32'd1);
        end
        chk("prog_final_pc", {24'd0, dut.pc_reg}, 32'd28);

        exp_regs = '{32'd0, 32'h33, 32'd1, 32'd12, 32'd12, 32'hE, 32'hA, 32'd1};
        for (int r = 0; r < 8; r++) begin
            chk($sformatf("dump_r%0d", r), dut.mrInst.registers[r], exp_regs[r]);
        end
        for (int i = 0; i < 256; i++) begin
            logic [31:0] e;
            e = (i == 2) ? 32'hA : (i == 13) ? 32'hC : (i == 82) ? 32'h33 : 32'd0;
            chk($sformatf("dump_dmem%0d", i), dut.mdInst.data_memory[i], e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
